pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage core. Merges stall requests from ID/EX/MEM
//  into the 6-bit pause vector consumed by pc_reg and every pipeline register
//  (bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB; 1=Stop).
//  Sequences the exception flush (flush + new_pc) and a debug halt/drain handshake.
//  Keeps a stall-cycle counter and a sticky stall-timeout flag.
// PARAMETERS
//  TIMEOUT  1024  consecutive stalled cycles before stall_timeout sets
//  CNT_W    32    width of stall_cnt
//  ADDR_W   32    width of excp_pc / new_pc
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  stallreq_id   in   1       ID requests stall (load-use)
//  stallreq_ex   in   1       EX requests stall (multi-cycle mult/div)
//  stallreq_mem  in   1       MEM requests stall (bus wait)
//  excp_req      in   1       MEM-stage exception/ERET commit
//  excp_pc       in   ADDR_W  handler/return address for excp_req
//  dbg_halt_req  in   1       level: debugger requests halt
//  pause         out  6       stall vector to pc_reg and pipeline registers
//  flush         out  1       clear all pipeline registers, load new_pc
//  new_pc        out  ADDR_W  redirect target, valid when flush=1, else 0
//  dbg_halted    out  1       pipeline drained and frozen
//  stall_timeout out  1       sticky: stall exceeded TIMEOUT cycles
//  stall_cnt     out  CNT_W   cycles with pause[0]=1 (RUN/HALTING), wraps
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=RUN, drain_cnt=0, to_cnt=0. Registered outputs
//   dbg_halted=0, stall_timeout=0, stall_cnt=0. While rst=1: pause=0, flush=0, new_pc=0.
//  pause/flush/new_pc are combinational from inputs + state (0-cycle latency).
//   Everything else updates at posedge.
//  States: RUN, FLUSH, HALTING, HALTED.
//  Stall pattern S: stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111;
//   else stallreq_id -> 6'b000111; else 6'b000000.
//  RUN:
//   excp_req=1 -> flush=1, new_pc=excp_pc, pause=0 (overrides all stalls); next FLUSH.
//   Otherwise pause=S, flush=0.
//   Next state: HALTING if dbg_halt_req=1, else RUN.
//  FLUSH (exactly 1 cycle): excp_req ignored (flush=0), pause=S.
//   Next: HALTING if dbg_halt_req, else RUN.
//  HALTING:
//   - pause = S | 6'b000011. IF/ID sees pause[1]=Stop with pause[2]=NoStop and injects bubbles.
//   - excp_req behaves as in RUN (flush; next FLUSH; drain_cnt cleared).
//   - drain_cnt increments on each cycle with S=0 and no flush.
//   - drain_cnt==3 on such a cycle -> next HALTED (4 bubble cycles empty ID..WB).
//   - dbg_halt_req=0 -> next RUN, drain_cnt=0 (takes priority over entering HALTED).
//  HALTED: pause=6'b111111, flush=0, excp_req and stallreqs ignored.
//   dbg_halt_req=0 -> next RUN.
//  dbg_halted is registered, 1 exactly in cycles where state==HALTED.
//   Falls with the transition to RUN.
//  stall_cnt: +1 per cycle with pause[0]=1 and state in {RUN, FLUSH, HALTING}.
//   Wraps 2^CNT_W-1 -> 0.
//  Timeout:
//   - to_cnt +1 per cycle with any stallreq_* = 1 outside HALTED, else cleared to 0.
//   - to_cnt saturates at TIMEOUT.
//   - stall_timeout sets on the edge where to_cnt reaches TIMEOUT. Stays 1 until rst.
//  Simultaneous events:
//   - excp_req beats all stalls and a new halt request; halt is honoured after FLUSH.
//   - rst mid-HALTING/HALTED returns to RUN and drops dbg_halted next cycle.
// TESTING
//  1. Only stallreq_ex=1 for 3 cycles -> pause=001111 each cycle, stall_cnt 0->3, flush=0.
//  2. stallreq_mem=1 & excp_req=1, excp_pc=32'h80000180 -> same cycle flush=1,
//     new_pc=80000180, pause=0. Next cycle excp_req held=1 -> flush=0 (FLUSH state).
//  3. dbg_halt_req=1, no stalls -> pause=000011 for 4 cycles, then pause=111111,
//     dbg_halted=1. Release -> dbg_halted=0 next cycle, pause=0.
//  4. HALTING with stallreq_id=1 for 2 cycles mid-drain -> drain paused, halt reached
//     2 cycles later (6 total).
//  5. TIMEOUT=8, stallreq_mem held 8 cycles -> stall_timeout=1 after 8th edge.
//     Drop request -> stays 1 until rst.
//  6. rst asserted in HALTED -> next cycle state RUN, dbg_halted=0, stall_cnt=0,
//     stall_timeout=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the 5-stage core.
//   Merges ID/EX/MEM stall requests into the pause vector, sequences the
//   exception flush, runs the debug halt/drain handshake and keeps stall
//   statistics plus a sticky stall-timeout flag.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   stallreq_id     load-use stall request from ID
//   stallreq_ex     multi-cycle mult/div stall request from EX
//   stallreq_mem    bus-wait stall request from MEM
//   excp_req        exception/ERET commit from MEM
//   excp_pc         handler/return address accompanying excp_req
//   dbg_halt_req    debugger halt request (level)
//   pause           stall vector, bit0=PC .. bit5=WB, 1 = stop (combinational)
//   flush           clear all pipeline registers and load new_pc (combinational)
//   new_pc          redirect target while flush=1, else 0 (combinational)
//   dbg_halted      pipeline drained and frozen (registered)
//   stall_timeout   sticky: stall lasted TIMEOUT consecutive cycles (registered)
//   stall_cnt       count of cycles with pause[0]=1 outside HALTED, wraps
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal operation, stalls passed through
// FLUSH   | one cycle after an exception redirect, excp_req ignored
// HALTING | PC/IF frozen, bubbles drain ID..WB until 4 clean cycles seen
// HALTED  | whole pipeline frozen until the debugger releases the halt
module pipe_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              excp_req,
    input  logic [ADDR_W-1:0] excp_pc,
    input  logic              dbg_halt_req,
    output logic [5:0]        pause,
    output logic              flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic              dbg_halted,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, HALTING, HALTED} state_t;

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [1:0]      drain_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [5:0]      stall_s;
    logic            any_stall;
    logic            take_excp;

    always_comb begin
        stall_s = 6'b000000;
        if (stallreq_mem)
            stall_s = 6'b011111;
        else if (stallreq_ex)
            stall_s = 6'b001111;
        else if (stallreq_id)
            stall_s = 6'b000111;

        any_stall = stallreq_id | stallreq_ex | stallreq_mem;
        take_excp = !rst && excp_req && (state == RUN || state == HALTING);

        pause = 6'b000000;
        if (!rst && !take_excp) begin
            case (state)
                RUN:     pause = stall_s;
                FLUSH:   pause = stall_s;
                // Freezing PC/IF while ID onwards keeps moving injects bubbles.
                HALTING: pause = stall_s | 6'b000011;
                HALTED:  pause = 6'b111111;
                default: pause = 6'b000000;
            endcase
        end

        flush  = take_excp;
        new_pc = take_excp ? excp_pc : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            drain_cnt     <= 2'd0;
            to_cnt        <= '0;
            dbg_halted    <= 1'b0;
            stall_timeout <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            if (pause[0] && state != HALTED)
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (any_stall && state != HALTED) begin
                if (to_cnt != TO_MAX)
                    to_cnt <= to_cnt + TO_W'(1);
                if (to_cnt >= TO_LAST)
                    stall_timeout <= 1'b1;
            end else begin
                to_cnt <= '0;
            end

            case (state)
                RUN, FLUSH: begin
                    drain_cnt  <= 2'd0;
                    dbg_halted <= 1'b0;
                    if (take_excp)
                        state <= FLUSH;
                    else if (dbg_halt_req)
                        state <= HALTING;
                    else
                        state <= RUN;
                end
                HALTING: begin
                    dbg_halted <= 1'b0;
                    if (take_excp) begin
                        state     <= FLUSH;
                        drain_cnt <= 2'd0;
                    end else if (!dbg_halt_req) begin
                        state     <= RUN;
                        drain_cnt <= 2'd0;
                    end else if (stall_s == 6'b000000) begin
                        // A stalled cycle does not advance the bubbles.
                        if (drain_cnt == 2'd3) begin
                            state      <= HALTED;
                            drain_cnt  <= 2'd0;
                            dbg_halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 2'd1;
                        end
                    end
                end
                HALTED: begin
                    drain_cnt <= 2'd0;
                    if (dbg_halt_req) begin
                        state      <= HALTED;
                        dbg_halted <= 1'b1;
                    end else begin
                        state      <= RUN;
                        dbg_halted <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    drain_cnt  <= 2'd0;
                    dbg_halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 8;
    localparam int ADDR_W  = 32;

    localparam int M_RUN     = 0;
    localparam int M_FLUSH   = 1;
    localparam int M_HALTING = 2;
    localparam int M_HALTED  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              stallreq_id, stallreq_ex, stallreq_mem;
    logic              excp_req;
    logic [ADDR_W-1:0] excp_pc;
    logic              dbg_halt_req;
    logic [5:0]        pause;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              dbg_halted;
    logic              stall_timeout;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_req(excp_req), .excp_pc(excp_pc), .dbg_halt_req(dbg_halt_req),
        .pause(pause), .flush(flush), .new_pc(new_pc),
        .dbg_halted(dbg_halted), .stall_timeout(stall_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]        pause;
        logic              flush;
        logic [ADDR_W-1:0] new_pc;
        logic              halted;
        logic              timeout;
        logic [CNT_W-1:0]  cnt;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  started  = 0;
    bit  done     = 0;

    // Reference model: abstract mode, bubble count, stall run length.
    int mode     = M_RUN;
    int bubbles  = 0;
    int stall_run = 0;
    bit sticky_to = 0;
    bit halted_r  = 0;
    int cnt_r     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !done) begin
            if (sb_q.size() == 0) begin
                chk("queue_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("pause",         64'(pause),         64'(e.pause));
                chk("flush",         64'(flush),         64'(e.flush));
                chk("new_pc",        64'(new_pc),        64'(e.new_pc));
                chk("dbg_halted",    64'(dbg_halted),    64'(e.halted));
                chk("stall_timeout", 64'(stall_timeout), 64'(e.timeout));
                chk("stall_cnt",     64'(stall_cnt),     64'(e.cnt));
            end
        end
    end

    task automatic drive(input bit r, input bit id, input bit ex, input bit mem,
                         input bit xr, input logic [ADDR_W-1:0] pc, input bit h);
        sb_t        e;
        logic [5:0] s;
        bit         take;
        int         nmode;
        @(posedge clk);
        #1;
        rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
        excp_req = xr; excp_pc = pc; dbg_halt_req = h;

        s = mem ? 6'b011111 : ex ? 6'b001111 : id ? 6'b000111 : 6'b000000;
        e.halted  = halted_r;
        e.timeout = sticky_to;
        e.cnt     = CNT_W'(cnt_r);
        e.pause   = 6'b0;
        e.flush   = 1'b0;
        e.new_pc  = '0;
        if (r) begin
            mode = M_RUN; bubbles = 0; stall_run = 0;
            sticky_to = 0; halted_r = 0; cnt_r = 0;
        end else begin
            take  = 0;
            nmode = mode;
            if (mode == M_RUN) begin
                take = xr;
                e.pause = s;
                nmode = take ? M_FLUSH : (h ? M_HALTING : M_RUN);
            end else if (mode == M_FLUSH) begin
                e.pause = s;
                nmode = h ? M_HALTING : M_RUN;
            end else if (mode == M_HALTING) begin
                take = xr;
                e.pause = s | 6'b000011;
                if (take) begin
                    nmode = M_FLUSH; bubbles = 0;
                end else if (!h) begin
                    nmode = M_RUN; bubbles = 0;
                end else if (s == 6'b0) begin
                    bubbles++;
                    if (bubbles == 4) begin
                        nmode = M_HALTED; bubbles = 0;
                    end
                end
            end else begin
                e.pause = 6'b111111;
                nmode = h ? M_HALTED : M_RUN;
            end
            if (take) begin
                e.flush = 1'b1; e.new_pc = pc; e.pause = 6'b0;
            end
            if (mode != M_HALTED && e.pause[0]) cnt_r = (cnt_r + 1) % (1 << CNT_W);
            if ((id || ex || mem) && mode != M_HALTED)
                stall_run = (stall_run < TIMEOUT) ? stall_run + 1 : TIMEOUT;
            else
                stall_run = 0;
            if (stall_run == TIMEOUT) sticky_to = 1;
            halted_r = (nmode == M_HALTED);
            mode = nmode;
        end
        sb_q.push_back(e);
        started = 1;
    endtask

    task automatic idle(input int n, input bit h);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0, h);
    endtask

    initial begin
        bit h;
        bit burst;
        rst = 1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excp_req = 0; excp_pc = '0; dbg_halt_req = 0;
        repeat (2) @(posedge clk);

        idle(2, 0);
        // EX-only stall for 3 cycles
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, '0, 0);
        idle(1, 0);
        // exception beats MEM stall, held request ignored in FLUSH
        drive(0, 0, 0, 1, 1, 32'h80000180, 0);
        drive(0, 0, 0, 0, 1, 32'h80000180, 0);
        idle(2, 0);
        // clean halt and release
        idle(7, 1);
        idle(3, 0);
        // halt with ID stall mid-drain
        idle(3, 1);
        drive(0, 1, 0, 0, 0, '0, 1);
        drive(0, 1, 0, 0, 0, '0, 1);
        idle(5, 1);
        // reset while halted
        drive(1, 0, 0, 0, 0, '0, 1);
        idle(2, 0);
        // timeout after TIMEOUT stalled cycles, sticky after release
        for (int i = 0; i < TIMEOUT + 2; i++) drive(0, 0, 0, 1, 0, '0, 0);
        idle(3, 0);
        // exception during HALTING, halt resumed after FLUSH
        idle(3, 1);
        drive(0, 0, 1, 0, 1, 32'h00001234, 1);
        idle(8, 1);
        drive(1, 0, 0, 0, 0, '0, 0);

        h = 0;
        burst = 0;
        for (int i = 0; i < 1500; i++) begin
            bit id, ex, mem, xr, r;
            if ($urandom_range(11) == 0) h = ~h;
            if ($urandom_range(29) == 0) burst = ~burst;
            id  = ($urandom_range(4) == 0);
            ex  = ($urandom_range(5) == 0);
            mem = burst ? 1'b1 : ($urandom_range(6) == 0);
            xr  = ($urandom_range(9) == 0);
            r   = ($urandom_range(399) == 0);
            drive(r, id, ex, mem, xr, ADDR_W'($urandom), h);
        end

        @(posedge clk);
        #1;
        done = 1;
        chk("queue_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
